// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the multicycle CPU. It owns the program counter
// and drives it as a word address into a combinational instruction memory. It
// latches the returned word into the instruction register (IR), together with
// the address it came from. The IR is offered downstream with a valid/ready
// handshake. PC-relative branch and jump redirects from execute are applied
// while an instruction is held.
//
// Optional feature: define FETCH_PERF_CNT_EN to add two 32-bit performance
// counters (captures and redirects taken). Without the macro those ports and
// their logic do not exist, and fetch behaviour is unchanged.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   run            in   1   leave IDLE and start fetching (sampled in IDLE)
//   stall          in   1   suppress the capture while in FETCH
//   imem_pc        out  32  word address to instruction memory (= pc_q)
//   imem_instr     in   32  instruction word for imem_pc (combinational)
//   ir             out  32  latched instruction
//   ir_pc          out  32  address ir was fetched from
//   ir_valid       out  1   ir/ir_pc hold an unconsumed instruction
//   ir_ready       in   1   downstream accepts ir this cycle
//   redirect       in   1   take a control transfer relative to ir_pc
//   redirect_jump  in   1   0: branch, imm16 = ir[15:0]; 1: jump, imm26 = ir[25:0]
//   perf_fetch_cnt out  32  instructions captured   (FETCH_PERF_CNT_EN only)
//   perf_redir_cnt out  32  redirects taken         (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        stall,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic        redirect_jump
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_redir_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_pc_q, ir_pc_d;

   // Single-cycle event strobes shared with the optional counters.
   logic        fetch_evt;
   logic        redir_evt;

   logic [31:0] redir_offset;
   logic [31:0] redir_target;

   // Offset is taken from the held IR, so the target is known as soon as the
   // instruction is valid. Target is relative to the instruction after ir_pc;
   // all arithmetic wraps modulo 2^32.
   always_comb begin
      if (redirect_jump) begin
         redir_offset = {{6{ir_q[25]}}, ir_q[25:0]};
      end else begin
         redir_offset = {{16{ir_q[15]}}, ir_q[15:0]};
      end
      redir_target = ir_pc_q + 32'd1 + redir_offset;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      ir_pc_d   = ir_pc_q;
      fetch_evt = 1'b0;
      redir_evt = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (!stall) begin
               ir_d      = imem_instr;
               ir_pc_d   = pc_q;
               pc_d      = pc_q + 32'd1;
               state_d   = ST_VALID;
               fetch_evt = 1'b1;
            end
         end

         ST_VALID: begin
            // A redirect consumes the IR on its own, whatever ir_ready says.
            if (redirect) begin
               pc_d      = redir_target;
               state_d   = ST_FETCH;
               redir_evt = 1'b1;
            end else if (ir_ready) begin
               // pc_q already points past ir_pc from the capture.
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
         ir_pc_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ir_pc_q <= ir_pc_d;
      end
   end

   assign imem_pc  = pc_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = (state_q == ST_VALID);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (fetch_evt) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (redir_evt) begin
         redir_cnt_d = redir_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
         redir_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard bench for fetch_stage. Stimulus pushes the expected (ir, ir_pc)
// of every instruction it expects to be consumed; a monitor pops and compares
// whenever the DUT hands an instruction over (ir_valid with ir_ready or
// redirect). Cycle-level properties (reset values, backpressure hold, stall,
// redirect address) are checked directly by the stimulus process.
// A second instance with RESET_PC = 0xFFFFFFFF covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        stall;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic        redirect_jump;

   logic        run2;
   logic [31:0] imem_pc2;
   logic [31:0] imem_instr2;
   logic [31:0] ir2;
   logic [31:0] ir_pc2;
   logic        ir_valid2;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_redir_cnt;
   logic [31:0] perf_fetch_cnt2;
   logic [31:0] perf_redir_cnt2;
`endif

   int   n_vec;
   int   n_err;
   exp_t exp_q[$];
   exp_t exp2_q[$];

   // Instruction memory image: entry 0 is the first instruction, 28 is a BEQ
   // with imm16 = 2, 30 is a J with imm26 = -3; everything else is a tag.
   function automatic logic [31:0] imem_f(input logic [31:0] a);
      logic [31:0] w;
      case (a)
         32'd0:   w = 32'hE400_FFFE;
         32'd28:  w = 32'h1000_0002;
         32'd30:  w = 32'h0BFF_FFFD;
         default: w = {16'hC0DE, a[15:0]};
      endcase
      return w;
   endfunction

   always_comb imem_instr  = imem_f(imem_pc);
   always_comb imem_instr2 = imem_f(imem_pc2);

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .stall         (stall),
      .imem_pc       (imem_pc),
      .imem_instr    (imem_instr),
      .ir            (ir),
      .ir_pc         (ir_pc),
      .ir_valid      (ir_valid),
      .ir_ready      (ir_ready),
      .redirect      (redirect),
      .redirect_jump (redirect_jump)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_redir_cnt(perf_redir_cnt)
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run2),
      .stall         (1'b0),
      .imem_pc       (imem_pc2),
      .imem_instr    (imem_instr2),
      .ir            (ir2),
      .ir_pc         (ir_pc2),
      .ir_valid      (ir_valid2),
      .ir_ready      (1'b1),
      .redirect      (1'b0),
      .redirect_jump (1'b0)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt2),
      .perf_redir_cnt(perf_redir_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid_pc(input logic [31:0] pc, input string name);
      for (int i = 0; i < 200; i++) begin
         step();
         if (ir_valid && ir_pc == pc) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for ir_pc %h", name, pc);
   endtask

   // Monitor, main instance: one pop per handed-over instruction.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && ir_valid && (ir_ready || redirect)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL mon_unexpected: got ir %h ir_pc %h, expected none", ir, ir_pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (ir !== e.instr || ir_pc !== e.pc) begin
                  n_err++;
                  $display("FAIL mon_xfer: got ir %h ir_pc %h, expected ir %h ir_pc %h",
                           ir, ir_pc, e.instr, e.pc);
               end else begin
                  $display("xfer ir_pc %h ir %h ok", ir_pc, ir);
               end
            end
         end
      end
   end

   // Monitor, wrap instance: checks only the captures it was told to expect.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && ir_valid2 && exp2_q.size() != 0) begin
            exp_t e;
            e = exp2_q.pop_front();
            n_vec++;
            if (ir2 !== e.instr || ir_pc2 !== e.pc) begin
               n_err++;
               $display("FAIL mon_wrap: got ir %h ir_pc %h, expected ir %h ir_pc %h",
                        ir2, ir_pc2, e.instr, e.pc);
            end else begin
               $display("wrap xfer ir_pc %h ir %h ok", ir_pc2, ir2);
            end
         end
      end
   end

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      run           = 1'b0;
      run2          = 1'b0;
      stall         = 1'b0;
      ir_ready      = 1'b0;
      redirect      = 1'b0;
      redirect_jump = 1'b0;

      // Reset state.
      #12;
      chk("reset_state", {95'd0, ir_valid, ir, ir_pc, imem_pc}, {95'd0, 1'b0, 32'd0, 32'd0, 32'd0});
      chk("reset_pc_wrap_inst", {96'd0, imem_pc2}, {96'd0, 32'hFFFF_FFFF});
`ifdef FETCH_PERF_CNT_EN
      chk("reset_perf", {64'd0, perf_fetch_cnt, perf_redir_cnt}, 128'd0);
`endif
      rst_n = 1'b1;
      step();
      step();
      chk("idle_no_run", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd0});

      // Sequential fetch 0..30, then jump at 30 back to 28, branch at 28 to 31.
      for (int k = 0; k <= 30; k++) begin
         exp_q.push_back('{instr: imem_f(k), pc: k});
      end
      exp_q.push_back('{instr: 32'h1000_0002, pc: 32'd28});
      exp_q.push_back('{instr: 32'hC0DE_001F, pc: 32'd31});
      ir_ready = 1'b1;
      run      = 1'b1;
      step();
      chk("fetch_after_run", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd0});
      step();
      chk("first_capture", {95'd0, ir_valid, ir, ir_pc}, {95'd0, 1'b1, 32'hE400_FFFE, 32'd0});
      step();
      chk("alternate_invalid", {96'd0, 31'd0, ir_valid}, {96'd0, 31'd0, 1'b0});
      step();
      chk("second_capture", {95'd0, ir_valid, ir_pc, imem_pc}, {95'd0, 1'b1, 32'd1, 32'd2});

      // Jump at ir_pc 30: 30 + 1 - 3 = 28.
      wait_valid_pc(32'd30, "wait_jump");
      redirect      = 1'b1;
      redirect_jump = 1'b1;
      step();
      redirect = 1'b0;
      chk("jump_target", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd28});
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redir_jump", {96'd0, perf_redir_cnt}, {96'd0, 32'd1});
`endif

      // Branch at ir_pc 28: 28 + 1 + 2 = 31.
      wait_valid_pc(32'd28, "wait_branch");
      redirect      = 1'b1;
      redirect_jump = 1'b0;
      step();
      redirect = 1'b0;
      ir_ready = 1'b0;
      chk("branch_target", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd31});

      // Backpressure: instruction 31 held for 5 cycles.
      step();
      for (int i = 0; i < 5; i++) begin
         chk("backpressure_hold", {31'd0, ir_valid, ir, ir_pc, imem_pc},
             {31'd0, 1'b1, 32'hC0DE_001F, 32'd31, 32'd32});
         step();
      end
      ir_ready = 1'b1;
      step();

      // Stall for 3 FETCH cycles, then capture on release.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_no_capture", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd32});
      end
      stall    = 1'b0;
      ir_ready = 1'b0;
      step();
      chk("capture_after_stall", {63'd0, ir_valid, ir, ir_pc}, {63'd0, 1'b1, 32'hC0DE_0020, 32'd32});
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt", {64'd0, perf_fetch_cnt, perf_redir_cnt}, {64'd0, 32'd34, 32'd2});
`endif

      // Asynchronous reset mid-VALID, between edges.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {95'd0, ir_valid, ir, ir_pc, imem_pc}, {95'd0, 1'b0, 32'd0, 32'd0, 32'd0});
`ifdef FETCH_PERF_CNT_EN
      chk("async_reset_perf", {64'd0, perf_fetch_cnt, perf_redir_cnt}, 128'd0);
`endif
      chk("scoreboard_drained", {96'd0, 32'(exp_q.size())}, 128'd0);
      #2;
      rst_n    = 1'b1;
      run      = 1'b0;
      ir_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_after_reset", {95'd0, ir_valid, imem_pc}, {95'd0, 1'b0, 32'd0});
      end

      // Wrap-around on the second instance.
      exp2_q.push_back('{instr: 32'hC0DE_FFFF, pc: 32'hFFFF_FFFF});
      exp2_q.push_back('{instr: 32'hE400_FFFE, pc: 32'd0});
      run2 = 1'b1;
      step();
      run2 = 1'b0;
      for (int i = 0; i < 20 && exp2_q.size() != 0; i++) begin
         step();
      end
      chk("wrap_drained", {96'd0, 32'(exp2_q.size())}, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the multicycle CPU, directly upstream of the instruction memory. It owns the program counter, drives the word address into the combinational instruction memory, and latches the returned word into the instruction register (IR). It presents the IR to decode/control with a valid/ready handshake and applies PC-relative branch and jump redirects issued by execute.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset (word address).
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `run`  in  1  — leave IDLE and begin fetching; level-sensitive, sampled only in IDLE.
- `stall`  in  1  — while high in FETCH, suppresses the capture.
- `imem_pc`  out  32  — word address to the instruction memory; always equals the internal `pc_q`.
- `imem_instr`  in  32  — instruction word returned combinationally for `imem_pc`.
- `ir`  out  32  — latched instruction.
- `ir_pc`  out  32  — address `ir` was fetched from.
- `ir_valid`  out  1  — `ir`/`ir_pc` hold an unconsumed instruction.
- `ir_ready`  in  1  — downstream accepts `ir` this cycle.
- `redirect`  in  1  — take a control transfer relative to `ir_pc`.
- `redirect_jump`  in  1  — offset select: 0 = branch, imm16 `ir[15:0]`; 1 = jump, imm26 `ir[25:0]`.
- `perf_fetch_cnt`  out  32  — instructions captured. Present only with the macro.
- `perf_redir_cnt`  out  32  — redirects taken. Present only with the macro.

## Operation
- **States:** IDLE, FETCH, VALID.
- **IDLE:** `ir_valid`=0. If `run`=1, go to FETCH.
- **FETCH:** `ir_valid`=0.
  - If `stall`=0, capture `ir`<=`imem_instr`, `ir_pc`<=`pc_q`, `pc_q`<=`pc_q`+1, and go to VALID.
  - If `stall`=1, hold all state and stay in FETCH.
- **VALID:** `ir_valid`=1. Evaluated in priority order:
  1. `redirect`=1: `pc_q`<=target and go to FETCH. The redirect also consumes the IR, regardless of `ir_ready`.
  2. `ir_ready`=1: go to FETCH; `pc_q` keeps its already-incremented value.
  3. Otherwise: hold everything.
- **Redirect target:** `ir_pc` + 1 + sign-extended offset. imm16 is used when `redirect_jump`=0; imm26 is used when `redirect_jump`=1.
- **Ignored inputs:**
  - `redirect` and `ir_ready` outside VALID.
  - `stall` outside FETCH.
  - `run` outside IDLE.
- **Arithmetic:** all PC arithmetic is 32-bit modulo 2^32. The increment from 0xFFFFFFFF wraps to 0. Negative offsets wrap the same way.
- **Reset outputs:** `pc_q`/`imem_pc`=`RESET_PC`, `ir`=0, `ir_pc`=0, `ir_valid`=0, state=IDLE, both counters=0.
- **Reset mid-operation:** the asynchronous assert clears everything above immediately, without waiting for a clock edge. A pending IR is discarded.

## Timing
- IMem is combinational, so `imem_instr` is sampled at the end of the same cycle the address is driven (the FETCH cycle).
- `run` high in IDLE → FETCH on the next edge → `ir_valid` high one edge after that.
- Best-case throughput is 1 instruction per 2 cycles (FETCH, VALID) when `ir_ready` is tied high.
- A redirect in VALID makes the target address appear on `imem_pc` in the following cycle (FETCH). The target's instruction is valid one edge later, so there is no wrong-path capture.
- While in VALID with `ir_ready`=0:
  - `ir`, `ir_pc`, `imem_pc` are stable.
  - `ir_valid` stays high.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `perf_fetch_cnt` increments on every FETCH capture.
  - `perf_redir_cnt` increments on every accepted redirect.
  - Both are 32-bit, wrap to 0, and are cleared by reset.
- **Undefined:** both ports and their counter logic are absent. Fetch behaviour is identical.

## Test plan
- **Sequential fetch:** reset, `run`=1, `ir_ready`=1, program 2 in IMem.
  - First capture: `ir`=0xE400FFFE, `ir_pc`=0.
  - Next captures: `ir_pc`=1, 2, 3…
  - `ir_valid` high on alternate cycles.
- **Branch:** at `ir_pc`=28 (BEQ, imm16=2), pulse `redirect`=1 with `redirect_jump`=0 → next `imem_pc`=31, next `ir_pc`=31.
- **Jump:** at `ir_pc`=30 (J, `ir[25:0]`=0x3FFFFFD), pulse `redirect`=1 with `redirect_jump`=1 → next `ir_pc`=28. `perf_redir_cnt` increments (macro on).
- **Backpressure and stall:**
  - `ir_ready`=0 for 5 cycles in VALID → `ir`, `ir_pc`, `imem_pc` unchanged and `ir_valid`=1 throughout.
  - `stall`=1 for 3 FETCH cycles → no capture; capture occurs on the first cycle `stall`=0.
- **Wrap-around:** `RESET_PC`=0xFFFFFFFF → first `ir_pc`=0xFFFFFFFF, second `ir_pc`=0.
- **Reset mid-VALID:** assert `rst_n`=0 between edges → immediately `ir_valid`=0, `ir`=0, `imem_pc`=`RESET_PC`, counters 0. After release, nothing happens until `run`=1.
